lsl8_seq: RTL and testbench

LSL8_SEQ -- requirements
Module: lsl8_seq

---
 rtl/lsl8_pkg.sv | 13 +
 rtl/lsl8_seq_if.sv | 28 ++
 rtl/lsl8_seq_down_cnt.sv | 39 +++
 rtl/lsl8_seq.sv | 93 +++++++++
 tb/tb_lsl8_seq.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/lsl8_pkg.sv
// rtl/lsl8_pkg.sv - shared state type and default sizes for the lsl8 sequential shifter
package lsl8_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int SHW_DEF   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/lsl8_seq_if.sv
// rtl/lsl8_seq_if.sv - request/result bundle between a shifter client and lsl8_seq
interface lsl8_seq_if
    import lsl8_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF
) ();

    logic             start;
    logic [WIDTH-1:0] d_in;
    logic [SHW-1:0]   shamt;
    logic             serial_in;
    logic [WIDTH-1:0] d_out;
    logic             so;
    logic             busy;
    logic             done;

    modport master (
        output start, d_in, shamt, serial_in,
        input  d_out, so, busy, done
    );

    modport slave (
        input  start, d_in, shamt, serial_in,
        output d_out, so, busy, done
    );

endinterface

// File: rtl/lsl8_seq_down_cnt.sv
// rtl/lsl8_seq_down_cnt.sv - loadable saturating down-counter holding the remaining shift count
module down_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o,
    output logic         one_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // load wins over decrement; decrement stops at zero so the count never wraps
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // count register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
    assign one_o  = (cnt_q == W'(1));

endmodule

// File: rtl/lsl8_seq.sv
// rtl/lsl8_seq.sv - multi-cycle left shifter: load, shift shamt times with serial fill, pulse done
module lsl8_seq
    import lsl8_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    lsl8_seq_if.slave   bus
);

    state_t           state_q;
    logic [WIDTH-1:0] reg_q;
    logic [WIDTH-1:0] shift_d;
    logic             so_q;
    logic             busy_q;
    logic             done_q;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             cnt_one;

    // start only counts in IDLE; the counter ticks once per shift cycle
    assign cnt_load = (state_q == IDLE) && bus.start;
    assign cnt_dec  = (state_q == SHIFT);
    assign shift_d  = {reg_q[WIDTH-2:0], bus.serial_in};

    down_cnt #(
        .W (SHW)
    ) u_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (cnt_load),
        .dec_i      (cnt_dec),
        .load_val_i (bus.shamt),
        .zero_o     (cnt_zero),
        .one_o      (cnt_one)
    );

    // control FSM with data register; busy/done are registered alongside the state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            reg_q   <= '0;
            so_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        reg_q  <= bus.d_in;
                        so_q   <= 1'b0;
                        busy_q <= 1'b1;
                        if (bus.shamt != '0) begin
                            state_q <= SHIFT;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    reg_q <= shift_d;
                    so_q  <= reg_q[WIDTH-1];
                    // zero is only a guard; a loaded count of zero never enters SHIFT
                    if (cnt_one || cnt_zero) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.d_out = reg_q;
    assign bus.so    = so_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_lsl8_seq.sv
// tb/tb_lsl8_seq.sv - scoreboard bench for lsl8_seq
module tb_lsl8_seq;
    import lsl8_pkg::*;

    typedef struct {
        logic [7:0] d;
        logic       so;
        int         cyc;
        int         busy;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   busy_cnt = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    lsl8_seq_if #(.WIDTH(8), .SHW(3)) bus ();

    lsl8_seq #(.WIDTH(8), .SHW(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 30; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout act=pending exp=empty cyc=%0d", cyc);
            sb.delete();
        end
    endtask

    task automatic hold_check(input logic [7:0] ed, input logic eso);
        repeat (3) @(negedge clk);
        chk("hold_d_out", bus.d_out, ed);
        chk("hold_so", bus.so, eso);
        chk("hold_busy", bus.busy, 1'b0);
    endtask

    task automatic run_op(input logic [7:0] d, input logic [2:0] sh, input logic sin,
                          input logic [7:0] ed, input logic eso);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.d_in = d;
        bus.shamt = sh;
        bus.serial_in = sin;
        @(posedge clk);
        #1;
        e = '{ed, eso, cyc + int'(sh), int'(sh) + 1};
        sb.push_back(e);
        bus.start = 1'b0;
        bus.d_in = d ^ 8'h5A;
        bus.shamt = ~sh;
        wait_empty();
        hold_check(ed, eso);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.d_in = 8'h00;
        bus.shamt = 3'd0;
        bus.serial_in = 1'b0;
        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (!reset_n) begin
                        busy_cnt = 0;
                    end else begin
                        if (bus.busy) busy_cnt++;
                        if (bus.done) begin
                            if (sb.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL spurious_done act=1 exp=0 cyc=%0d", cyc);
                            end else begin
                                e = sb.pop_front();
                                chk("d_out", bus.d_out, e.d);
                                chk("so", bus.so, e.so);
                                chk("done_cycle", cyc, e.cyc);
                                chk("busy_cycles", busy_cnt, e.busy);
                            end
                            busy_cnt = 0;
                        end
                    end
                end
            end
            begin : stimulus
                exp_t e;
                int   c0;
                repeat (2) @(negedge clk);
                chk("rst_d_out", bus.d_out, 8'h00);
                chk("rst_so", bus.so, 1'b0);
                chk("rst_busy", bus.busy, 1'b0);
                chk("rst_done", bus.done, 1'b0);
                @(negedge clk);
                reset_n = 1'b1;

                run_op(8'h1F, 3'd3, 1'b0, 8'hF8, 1'b0);
                run_op(8'hFF, 3'd3, 1'b0, 8'hF8, 1'b1);
                run_op(8'hA5, 3'd0, 1'b0, 8'hA5, 1'b0);
                run_op(8'h00, 3'd7, 1'b1, 8'h7F, 1'b0);

                // starts during SHIFT and during DONE must be ignored
                @(negedge clk);
                bus.start = 1'b1;
                bus.d_in = 8'h81;
                bus.shamt = 3'd5;
                bus.serial_in = 1'b0;
                @(posedge clk);
                #1;
                c0 = cyc;
                e = '{8'h20, 1'b0, c0 + 5, 6};
                sb.push_back(e);
                bus.start = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    case (cyc - c0)
                        2: begin
                            bus.start = 1'b1;
                            bus.d_in = 8'h3C;
                            bus.shamt = 3'd2;
                        end
                        3: bus.start = 1'b0;
                        5: bus.start = 1'b1;
                        6: bus.start = 1'b0;
                        default: ;
                    endcase
                end
                wait_empty();
                hold_check(8'h20, 1'b0);

                // reset after two shifts aborts with no done
                @(negedge clk);
                bus.start = 1'b1;
                bus.d_in = 8'h55;
                bus.shamt = 3'd6;
                bus.serial_in = 1'b0;
                @(posedge clk);
                #1;
                bus.start = 1'b0;
                @(posedge clk);
                @(posedge clk);
                #3;
                reset_n = 1'b0;
                #1;
                chk("abort_d_out", bus.d_out, 8'h00);
                chk("abort_so", bus.so, 1'b0);
                chk("abort_busy", bus.busy, 1'b0);
                chk("abort_done", bus.done, 1'b0);
                @(negedge clk);
                @(negedge clk);
                reset_n = 1'b1;
                run_op(8'h01, 3'd1, 1'b0, 8'h02, 1'b0);

                repeat (4) @(negedge clk);
                chk("sb_empty", sb.size(), 0);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        join
    end

endmodule
